// File: rtl/instr_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit words,
// writes them at consecutive word addresses and holds the core in reset while loading.
module instr_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_word_idx;
    logic [1:0]          r_byte_idx;
    logic [WORD_W-1:0]   r_buf;
    logic                r_error;
    logic [CNT_W-1:0]    r_words_loaded;
    logic                r_byte_ready;
    logic                r_mem_we;
    logic [WORD_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic                r_busy;
    logic                r_cpu_hold;
    logic                r_done;

    state_t              w_next_state;
    logic [CNT_W-1:0]    w_len;
    logic [CNT_W-1:0]    w_word_idx;
    logic [CNT_W-1:0]    w_word_inc;
    logic [1:0]          w_byte_idx;
    logic [WORD_W-1:0]   w_buf;
    logic                w_error;
    logic [CNT_W-1:0]    w_words_loaded;
    logic                w_byte_ready;
    logic                w_mem_we;
    logic [WORD_W-1:0]   w_mem_addr;
    logic [WORD_W-1:0]   w_mem_wdata;
    logic                w_busy;
    logic                w_cpu_hold;
    logic                w_done;

    assign w_word_inc = r_word_idx + CNT_W'(1);

    // State, datapath and output registers; outputs are loaded from next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_word_idx     <= '0;
            r_byte_idx     <= '0;
            r_buf          <= '0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
            r_byte_ready   <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_busy         <= 1'b0;
            r_cpu_hold     <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_len          <= w_len;
            r_word_idx     <= w_word_idx;
            r_byte_idx     <= w_byte_idx;
            r_buf          <= w_buf;
            r_error        <= w_error;
            r_words_loaded <= w_words_loaded;
            r_byte_ready   <= w_byte_ready;
            r_mem_we       <= w_mem_we;
            r_mem_addr     <= w_mem_addr;
            r_mem_wdata    <= w_mem_wdata;
            r_busy         <= w_busy;
            r_cpu_hold     <= w_cpu_hold;
            r_done         <= w_done;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_next_state   = r_state;
        w_len          = r_len;
        w_word_idx     = r_word_idx;
        w_byte_idx     = r_byte_idx;
        w_buf          = r_buf;
        w_error        = r_error;
        w_words_loaded = r_words_loaded;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len          = len_words;
                    w_error        = 1'b0;
                    w_words_loaded = '0;
                    w_word_idx     = '0;
                    w_byte_idx     = '0;
                    w_buf          = '0;
                    if (len_words == '0) begin
                        w_next_state = S_DONE;
                    end else if (len_words > LEN_MAX) begin
                        w_error = 1'b1;
                    end else begin
                        w_next_state = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (byte_valid && r_byte_ready) begin
                    w_buf[{r_byte_idx, 3'b000} +: BYTE_W] = byte_data;
                    w_byte_idx = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        w_next_state = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_words_loaded = w_word_inc;
                w_word_idx     = w_word_inc;
                w_byte_idx     = '0;
                w_next_state   = (w_word_inc == r_len) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state; the bus carries zeros outside the write cycle.
    always_comb begin
        w_byte_ready = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_busy       = 1'b0;
        w_cpu_hold   = 1'b0;
        w_done       = 1'b0;
        case (w_next_state)
            S_RECV: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
                w_cpu_hold   = 1'b1;
            end
            S_WRITE: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = WORD_W'({w_word_idx, 2'b00});
                w_mem_wdata = w_buf;
                w_busy      = 1'b1;
                w_cpu_hold  = 1'b1;
            end
            S_DONE: begin
                w_done     = 1'b1;
                w_cpu_hold = 1'b1;
            end
            default: begin
                w_byte_ready = 1'b0;
            end
        endcase
    end

    assign byte_ready   = r_byte_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = r_busy;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table-driven loads, randomized loads against a
// byte-stream-to-word model, and hand-written reset/error/held-start sequences.
module tb_instr_loader;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len_words = '0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = '0;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             cpu_hold;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    instr_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len_words    (len_words),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Written only by the monitor.
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          done_cnt = 0;
    int          viol_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
        if (done) done_cnt++;
        if ((!mem_we && (mem_addr != 32'd0 || mem_wdata != 32'd0)) ||
            (busy && !cpu_hold) || (mem_addr[1:0] != 2'b00) ||
            (byte_ready && mem_we) || (mem_addr > 32'(4 * (DEPTH - 1))))
            viol_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({byte_ready, mem_we, busy, cpu_hold, done, error}), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    // Program image: kind 0 random words, 1 word i = i, 2 word i = 0xB3 - 0x10*i.
    task automatic make_bytes(input int len, input int kind, output logic [7:0] q[$]);
        logic [31:0] w;
        q = {};
        for (int i = 0; i < len; i++) begin
            if (kind == 1)      w = 32'(i);
            else if (kind == 2) w = 32'h0000_00B3 - 32'(16 * i);
            else                w = $urandom;
            for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
        end
    endtask

    // Present bytes with random gaps; returns at posedge+1 after the last handshake.
    task automatic feed(input logic [7:0] bq[$], input int gap, input string tag);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < bq.size() && guard < 20000) begin
            guard++;
            if (int'($urandom_range(99)) < gap) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = bq[i];
            end
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) i++;
        end
        byte_valid = 1'b0;
        chk({tag, "_bytes_taken"}, 32'(i), 32'(bq.size()));
    endtask

    // Feed the bytes, wait for done, then compare every write with the packed byte stream.
    task automatic complete(input int len, input logic [7:0] bq[$], input int gap,
                            input string tag, input int base, input int bd, input int bv);
        int          n = 0;
        logic [31:0] exp_w;
        feed(bq, gap, tag);
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hold_in_done"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(len));
        @(posedge clk); #1;
        chk({tag, "_after_done"}, 32'({cpu_hold, busy, done}), 32'd0);
        chk({tag, "_nwrites"}, 32'(wq_addr.size() - base), 32'(len));
        for (int i = 0; i < len && base + i < wq_addr.size(); i++) begin
            exp_w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
            chk($sformatf("%s_addr%0d", tag, i), wq_addr[base+i], 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), wq_data[base+i], exp_w);
        end
        chk({tag, "_done_pulses"}, 32'(done_cnt - bd), 32'd1);
        chk({tag, "_bus_rules"}, 32'(viol_cnt - bv), 32'd0);
    endtask

    task automatic run_load(input int len, input logic [7:0] bq[$], input int gap,
                            input bit hold, input string tag, output int base);
        int bd;
        int bv;
        base = wq_addr.size();
        bd   = done_cnt;
        bv   = viol_cnt;
        start     = 1'b1;
        len_words = CNT_W'(len);
        @(posedge clk); #1;
        if (!hold) begin
            start     = 1'b0;
            len_words = CNT_W'($urandom);
        end
        complete(len, bq, gap, tag, base, bd, bv);
    endtask

    typedef struct {
        int          len;
        int          gap;
        int          kind;
        logic [31:0] exp_last_addr;
        logic [31:0] exp_first_data;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    initial begin
        logic [7:0] bq[$];
        logic [7:0] bq2[$];
        logic [7:0] empty_q[$];
        int         base;
        int         bd;
        int         bv;
        int         n;

        vecs[0] = '{len: 1,  gap: 0,  kind: 2, exp_last_addr: 32'h00, exp_first_data: 32'h0000_00B3};
        vecs[1] = '{len: 2,  gap: 40, kind: 2, exp_last_addr: 32'h04, exp_first_data: 32'h0000_00B3};
        vecs[2] = '{len: 64, gap: 0,  kind: 1, exp_last_addr: 32'hFC, exp_first_data: 32'h0000_0000};
        vecs[3] = '{len: 5,  gap: 30, kind: 0, exp_last_addr: 32'h10, exp_first_data: 32'h0};
        vecs[4] = '{len: 3,  gap: 70, kind: 0, exp_last_addr: 32'h08, exp_first_data: 32'h0};
        empty_q = {};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < NV; t++) begin
            make_bytes(vecs[t].len, vecs[t].kind, bq);
            run_load(vecs[t].len, bq, vecs[t].gap, 1'b0, $sformatf("vec%0d", t), base);
            if (wq_addr.size() > base) begin
                chk($sformatf("vec%0d_last_addr", t), wq_addr[wq_addr.size()-1], vecs[t].exp_last_addr);
                if (vecs[t].kind != 0)
                    chk($sformatf("vec%0d_first_data", t), wq_data[base], vecs[t].exp_first_data);
            end
        end

        // Reset after two bytes of a one-word load: the partial word is discarded.
        base = wq_addr.size();
        start = 1'b1;
        len_words = CNT_W'(1);
        @(posedge clk); #1;
        start = 1'b0;
        bq = {8'hAA, 8'hBB};
        feed(bq, 0, "abort");
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_no_write", 32'(wq_addr.size() - base), 32'd0);
        bq = {8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, bq, 0, 1'b0, "postrst", base);
        if (wq_data.size() > base)
            chk("postrst_word", wq_data[base], 32'h4433_2211);

        // Oversize length: sticky error, no activity; a zero-length start clears it.
        base = wq_addr.size();
        bd = done_cnt;
        start = 1'b1;
        len_words = CNT_W'(DEPTH + 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("len65_error", 32'(error), 32'd1);
        chk("len65_idle", 32'({busy, cpu_hold, byte_ready}), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("len65_sticky", 32'(error), 32'd1);
        chk("len65_no_write", 32'(wq_addr.size() - base), 32'd0);
        chk("len65_no_done", 32'(done_cnt - bd), 32'd0);
        run_load(0, empty_q, 0, 1'b0, "len0", base);
        chk("len0_error_clr", 32'(error), 32'd0);

        // start held high for the whole load, then it restarts from IDLE.
        make_bytes(2, 1, bq);
        run_load(2, bq, 25, 1'b1, "held", base);
        base = wq_addr.size();
        bd = done_cnt;
        bv = viol_cnt;
        n = 0;
        while (busy !== 1'b1 && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_restart", 32'(busy), 32'd1);
        start = 1'b0;
        make_bytes(2, 0, bq2);
        complete(2, bq2, 20, "restart", base, bd, bv);

        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(12, 1));
            make_bytes(n, 0, bq);
            run_load(n, bq, int'($urandom_range(60)), 1'b0, $sformatf("rnd%0d", r), base);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
